// File: rtl/traffic_light_pkg.sv
// Shared phase encoding and legal-successor rule for the R/G lamp monitor.
package traffic_light_pkg;

  typedef enum logic [1:0] {
    PH_DARK   = 2'b00,
    PH_GREEN  = 2'b01,
    PH_RED    = 2'b10,
    PH_YELLOW = 2'b11
  } phase_t;

  // DARK only ever leads into YELLOW; lit phases rotate YELLOW->RED->GREEN->YELLOW.
  function automatic phase_t ph_next_legal(input phase_t ph);
    phase_t nxt;
    case (ph)
      PH_DARK:   nxt = PH_YELLOW;
      PH_YELLOW: nxt = PH_RED;
      PH_RED:    nxt = PH_GREEN;
      PH_GREEN:  nxt = PH_YELLOW;
      default:   nxt = PH_YELLOW;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous load-to-one, used for dwell and cycle counts.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         load_one,
  output logic [W-1:0] count
);

  // Load takes priority over increment; increment stops at all-ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load_one) begin
      count <= W'(1);
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end else begin
      count <= count;
    end
  end

endmodule

// File: rtl/traffic_light_monitor.sv
// Receive-side checker for the R/G lamp lines: decodes phase, measures dwell,
// flags illegal orderings and out-of-tolerance dwell, and counts completed cycles.
module traffic_light_monitor
  import traffic_light_pkg::*;
#(
  parameter int DWELL = 11,
  parameter int TOL   = 0,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             r_in,
  input  logic             g_in,
  input  logic             err_clr,
  output logic [1:0]       phase,
  output logic [CNT_W-1:0] dwell_cnt,
  output logic             phase_change,
  output logic             cycle_done,
  output logic [15:0]      cycle_cnt,
  output logic             seq_err,
  output logic             dwell_err
);

  // One extra bit so DWELL+TOL+1 never wraps in the comparisons.
  localparam logic [CNT_W:0] SHORT_LIM = (CNT_W+1)'(DWELL - TOL);
  localparam logic [CNT_W:0] STUCK_LIM = (CNT_W+1)'(DWELL + TOL + 1);

  phase_t         cur_ph;
  phase_t         new_ph;
  phase_t         expect_ph;
  logic           changed;
  logic           seq_ev;
  logic           dwell_ev;
  logic           cycle_ev;
  logic           seq_next;
  logic           dwell_next;
  logic           pc_q;
  logic           cd_q;
  logic           seq_q;
  logic           dwell_q;
  logic [CNT_W:0] dwell_plus;

  always_comb begin
    new_ph     = phase_t'({r_in, g_in});
    expect_ph  = ph_next_legal(cur_ph);
    changed    = (new_ph != cur_ph);
    dwell_plus = {1'b0, dwell_cnt} + {{CNT_W{1'b0}}, 1'b1};
    seq_ev     = changed && (new_ph != expect_ph);
    dwell_ev   = 1'b0;
    if (cur_ph == PH_DARK) begin
      dwell_ev = 1'b0;
    end else if (changed) begin
      dwell_ev = ({1'b0, dwell_cnt} < SHORT_LIM);
    end else begin
      dwell_ev = (dwell_plus == STUCK_LIM);
    end
    cycle_ev   = changed && (cur_ph == PH_GREEN) && (new_ph == PH_YELLOW);
    // A fresh error event outranks a same-cycle clear.
    seq_next   = seq_ev   | (seq_q   & ~err_clr);
    dwell_next = dwell_ev | (dwell_q & ~err_clr);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_ph  <= PH_DARK;
      pc_q    <= 1'b0;
      cd_q    <= 1'b0;
      seq_q   <= 1'b0;
      dwell_q <= 1'b0;
    end else begin
      cur_ph  <= new_ph;
      pc_q    <= changed;
      cd_q    <= cycle_ev;
      seq_q   <= seq_next;
      dwell_q <= dwell_next;
    end
  end

  sat_counter #(.W(CNT_W)) u_dwell (
    .clk      (clk),
    .reset    (reset),
    .inc      (!changed),
    .load_one (changed),
    .count    (dwell_cnt)
  );

  sat_counter #(.W(16)) u_cycle (
    .clk      (clk),
    .reset    (reset),
    .inc      (cycle_ev),
    .load_one (1'b0),
    .count    (cycle_cnt)
  );

  assign phase        = cur_ph;
  assign phase_change = pc_q;
  assign cycle_done   = cd_q;
  assign seq_err      = seq_q;
  assign dwell_err    = dwell_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Directed self-checking bench for traffic_light_monitor with DWELL=11, TOL=0.
module tb_traffic_light_monitor;

  logic        clk = 1'b0;
  logic        reset;
  logic        r_in;
  logic        g_in;
  logic        err_clr;
  logic [1:0]  phase;
  logic [7:0]  dwell_cnt;
  logic        phase_change;
  logic        cycle_done;
  logic [15:0] cycle_cnt;
  logic        seq_err;
  logic        dwell_err;

  int errors = 0;
  int checks = 0;
  int pc_cnt = 0;
  int cd_cnt = 0;

  traffic_light_monitor #(.DWELL(11), .TOL(0), .CNT_W(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .r_in         (r_in),
    .g_in         (g_in),
    .err_clr      (err_clr),
    .phase        (phase),
    .dwell_cnt    (dwell_cnt),
    .phase_change (phase_change),
    .cycle_done   (cycle_done),
    .cycle_cnt    (cycle_cnt),
    .seq_err      (seq_err),
    .dwell_err    (dwell_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive {r,g} for n edges; sample 1 time unit after each edge.
  task automatic cyc(input logic [1:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      r_in = v[1];
      g_in = v[0];
      @(posedge clk);
      #1;
      pc_cnt += int'(phase_change);
      cd_cnt += int'(cycle_done);
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_phase"}, 32'(phase), 32'd0);
    chk({tag, "_dwell"}, 32'(dwell_cnt), 32'd0);
    chk({tag, "_pc"}, 32'(phase_change), 32'd0);
    chk({tag, "_cd"}, 32'(cycle_done), 32'd0);
    chk({tag, "_ccnt"}, 32'(cycle_cnt), 32'd0);
    chk({tag, "_seq"}, 32'(seq_err), 32'd0);
    chk({tag, "_dwerr"}, 32'(dwell_err), 32'd0);
  endtask

  initial begin
    reset   = 1'b1;
    r_in    = 1'b0;
    g_in    = 1'b0;
    err_clr = 1'b0;
    #2;
    chk_reset_state("por");
    @(negedge clk);
    reset = 1'b0;

    // Nominal sequence
    cyc(2'b00, 5);
    chk("dark_phase", 32'(phase), 32'd0);
    chk("dark_dwell", 32'(dwell_cnt), 32'd5);
    cyc(2'b11, 1);
    chk("y_phase", 32'(phase), 32'd3);
    chk("y_dwell1", 32'(dwell_cnt), 32'd1);
    chk("y_pc", 32'(phase_change), 32'd1);
    cyc(2'b11, 10);
    chk("y_dwell11", 32'(dwell_cnt), 32'd11);
    cyc(2'b10, 11);
    chk("r_phase", 32'(phase), 32'd2);
    cyc(2'b01, 11);
    chk("g_phase", 32'(phase), 32'd1);
    chk("g_dwell11", 32'(dwell_cnt), 32'd11);
    chk("g_cd0", 32'(cycle_done), 32'd0);
    cyc(2'b11, 1);
    chk("nom_cd", 32'(cycle_done), 32'd1);
    chk("nom_ccnt", 32'(cycle_cnt), 32'd1);
    chk("nom_pcs", 32'(pc_cnt), 32'd4);
    chk("nom_cds", 32'(cd_cnt), 32'd1);
    chk("nom_seq", 32'(seq_err), 32'd0);
    chk("nom_dwerr", 32'(dwell_err), 32'd0);
    cyc(2'b11, 1);
    chk("nom_cd_drop", 32'(cycle_done), 32'd0);
    chk("nom_pc_drop", 32'(phase_change), 32'd0);

    // Short dwell: RED held 9 then GREEN
    cyc(2'b11, 9);
    cyc(2'b10, 9);
    chk("short_before", 32'(dwell_err), 32'd0);
    cyc(2'b01, 1);
    chk("short_dwerr", 32'(dwell_err), 32'd1);
    chk("short_seq", 32'(seq_err), 32'd0);
    chk("short_dwell", 32'(dwell_cnt), 32'd1);

    // err_clr alone clears the flag
    err_clr = 1'b1;
    cyc(2'b01, 1);
    err_clr = 1'b0;
    chk("clr_dwerr", 32'(dwell_err), 32'd0);

    // Stuck GREEN
    cyc(2'b01, 9);
    chk("stuck_11", 32'(dwell_cnt), 32'd11);
    chk("stuck_noerr", 32'(dwell_err), 32'd0);
    cyc(2'b01, 1);
    chk("stuck_12", 32'(dwell_cnt), 32'd12);
    chk("stuck_err", 32'(dwell_err), 32'd1);
    cyc(2'b01, 243);
    chk("stuck_255", 32'(dwell_cnt), 32'd255);
    cyc(2'b01, 5);
    chk("stuck_hold", 32'(dwell_cnt), 32'd255);
    err_clr = 1'b1;
    cyc(2'b01, 1);
    err_clr = 1'b0;
    chk("stuck_clr", 32'(dwell_err), 32'd0);

    // YELLOW -> GREEN is illegal, no cycle_done
    cyc(2'b11, 1);
    chk("y2_cd", 32'(cycle_done), 32'd1);
    chk("y2_ccnt", 32'(cycle_cnt), 32'd2);
    cyc(2'b11, 10);
    cyc(2'b01, 1);
    chk("yg_seq", 32'(seq_err), 32'd1);
    chk("yg_cd", 32'(cycle_done), 32'd0);
    chk("yg_ccnt", 32'(cycle_cnt), 32'd2);
    chk("yg_dwerr", 32'(dwell_err), 32'd0);
    err_clr = 1'b1;
    cyc(2'b01, 1);
    err_clr = 1'b0;
    chk("yg_clr", 32'(seq_err), 32'd0);
    // Resynchronised: GREEN -> YELLOW now legal
    cyc(2'b01, 9);
    cyc(2'b11, 1);
    chk("resync_seq", 32'(seq_err), 32'd0);
    chk("resync_ccnt", 32'(cycle_cnt), 32'd3);
    cyc(2'b11, 10);
    cyc(2'b10, 5);
    chk("pre_rst_phase", 32'(phase), 32'd2);
    chk("pre_rst_ccnt", 32'(cycle_cnt), 32'd3);

    // Reset mid-RED, checked before any clock edge
    reset = 1'b1;
    r_in  = 1'b0;
    g_in  = 1'b0;
    #1;
    chk_reset_state("mid");
    #2;
    reset = 1'b0;

    // Nominal sequence after reset
    pc_cnt = 0;
    cd_cnt = 0;
    cyc(2'b00, 3);
    cyc(2'b11, 11);
    cyc(2'b10, 11);
    cyc(2'b01, 11);
    cyc(2'b11, 1);
    chk("re_ccnt", 32'(cycle_cnt), 32'd1);
    chk("re_pcs", 32'(pc_cnt), 32'd4);
    chk("re_seq", 32'(seq_err), 32'd0);
    chk("re_dwerr", 32'(dwell_err), 32'd0);

    // RED -> DARK is illegal
    cyc(2'b11, 10);
    cyc(2'b10, 11);
    cyc(2'b00, 1);
    chk("rd_seq", 32'(seq_err), 32'd1);
    chk("rd_phase", 32'(phase), 32'd0);
    chk("rd_dwerr", 32'(dwell_err), 32'd0);

    // After reset, DARK -> RED is illegal
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rst2_seq", 32'(seq_err), 32'd0);
    reset = 1'b0;
    cyc(2'b00, 2);
    cyc(2'b10, 1);
    chk("dr_seq", 32'(seq_err), 32'd1);
    chk("dr_phase", 32'(phase), 32'd2);

    // err_clr coincides with short-dwell RED -> GREEN
    err_clr = 1'b1;
    cyc(2'b01, 1);
    err_clr = 1'b0;
    chk("clr_race_seq", 32'(seq_err), 32'd0);
    chk("clr_race_dwerr", 32'(dwell_err), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
